uart_recv: RTL and testbench

//  UART receiver, 8N1 (8E1 with parity option). Counterpart and downstream consumer of the uart_send TX line.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_recv.sv | 155 +++++++++++++++
 tb/tb_uart_recv.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, bit-period helper, data width.
// UART_RECV_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

   localparam int DATA_W = 8;

`ifdef UART_RECV_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

   function automatic int bps_cnt(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// 2-FF synchronizer for an asynchronous input plus falling-edge detect on the
// synchronized value. All stages reset to RST_VAL so no false edge leaves reset.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o,
   output logic fall_o
);

   // [0],[1] synchronize; [2] holds the previous synchronized sample
   logic [2:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= {3{RST_VAL}};
      else       sync_q <= {sync_q[1:0], async_i};
   end

   assign sync_o = sync_q[1];
   assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1 by default; define UART_RECV_PARITY_EN for 8E1 with
// even-parity checking. One byte per good frame with a 1-cycle done strobe.
module uart_recv
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              uart_rxd,
   output logic [DATA_W-1:0] uart_dout,
   output logic              uart_rx_done,
   output logic              uart_rx_busy,
   output logic              frame_err,
   output logic              parity_err
);

   localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
   localparam int HALF    = BPS_CNT / 2;
   localparam int CNT_W   = $clog2(BPS_CNT);
   localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic rx_s, rx_fall;

   uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .async_i (uart_rxd),
      .sync_o  (rx_s),
      .fall_o  (rx_fall)
   );

   state_t            state_q;
   logic [CNT_W-1:0]  clk_cnt_q;
   logic [2:0]        bit_idx_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] dout_q;
   logic              done_q, busy_q, ferr_q;
   logic              par_bad;

`ifdef UART_RECV_PARITY_EN
   logic par_bad_q, perr_q;
   assign par_bad    = par_bad_q;
   assign parity_err = perr_q;
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

   // Every state after START samples once per bit period; START samples at
   // half a period so all later samples land mid-bit.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         dout_q    <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RECV_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
`ifdef UART_RECV_PARITY_EN
         perr_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (rx_fall) begin
                  state_q   <= ST_START;
                  clk_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            ST_START: begin
               if (clk_cnt_q == CNT_HALF_M1) begin
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  if (!rx_s) begin
                     state_q <= ST_DATA;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (clk_cnt_q == CNT_LAST) begin
                  clk_cnt_q         <= '0;
                  data_q[bit_idx_q] <= rx_s;
                  bit_idx_q         <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
`ifdef UART_RECV_PARITY_EN
            ST_PARITY: begin
               if (clk_cnt_q == CNT_LAST) begin
                  clk_cnt_q <= '0;
                  par_bad_q <= (^data_q) ^ rx_s;
                  state_q   <= ST_STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
`endif
            ST_STOP: begin
               // Leaving at mid-stop lets a back-to-back start edge be caught
               if (clk_cnt_q == CNT_LAST) begin
                  clk_cnt_q <= '0;
                  state_q   <= ST_IDLE;
                  busy_q    <= 1'b0;
                  ferr_q    <= ~rx_s;
`ifdef UART_RECV_PARITY_EN
                  perr_q    <= par_bad_q;
`endif
                  if (rx_s && !par_bad) begin
                     dout_q <= data_q;
                     done_q <= 1'b1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign uart_dout    = dout_q;
   assign uart_rx_done = done_q;
   assign uart_rx_busy = busy_q;
   assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: behavioural serial driver, event monitor,
// and a frame-level reference model (good frame <=> stop high and parity ok).
module tb_uart_recv;

   localparam int CLK_FREQ = 1000000;
   localparam int UART_BPS = 62500;
   localparam int BPS      = CLK_FREQ / UART_BPS;
   localparam int HALF     = BPS / 2;
`ifdef UART_RECV_PARITY_EN
   localparam int NBITS = 11;
   localparam bit PAR   = 1'b1;
`else
   localparam int NBITS = 10;
   localparam bit PAR   = 1'b0;
`endif
   localparam longint LAT = longint'((NBITS - 1) * BPS + HALF + 3);

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       uart_rxd = 1'b1;
   logic [7:0] uart_dout;
   logic       uart_rx_done, uart_rx_busy, frame_err, parity_err;

   uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .uart_rxd     (uart_rxd),
      .uart_dout    (uart_dout),
      .uart_rx_done (uart_rx_done),
      .uart_rx_busy (uart_rx_busy),
      .frame_err    (frame_err),
      .parity_err   (parity_err)
   );

   always #10 sys_clk = ~sys_clk;

   int n_chk = 0, n_fail = 0;
   int n_done = 0, n_ferr = 0, n_perr = 0, n_busy_rise = 0;
   logic busy_prev = 1'b0;
   longint cyc = 0;
   longint fall_cyc = 0;
   longint done_cyc[$];
   logic [7:0] done_byte[$];
   logic [7:0] exp_dout = 8'h00;

   always @(posedge sys_clk) cyc++;

   always @(negedge sys_clk) begin
      if (uart_rx_done) begin
         n_done++;
         done_cyc.push_back(cyc);
         done_byte.push_back(uart_dout);
      end
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (uart_rx_busy && !busy_prev) n_busy_rise++;
      busy_prev = uart_rx_busy;
   end

   task automatic bit_time(input logic v);
      uart_rxd = v;
      repeat (BPS) @(negedge sys_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bit);
      @(negedge sys_clk);
      fall_cyc = cyc;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (PAR) bit_time(par_bit);
      bit_time(stop);
   endtask

   task automatic idle_bits(input int n);
      uart_rxd = 1'b1;
      repeat (n * BPS) @(negedge sys_clk);
   endtask

   task automatic test_reset;
      sys_rst = 1'b1;
      uart_rxd = 1'b1;
      repeat (3) @(negedge sys_clk);
      n_chk++;
      if ({uart_dout, uart_rx_done, uart_rx_busy, frame_err, parity_err} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 000",
                  {uart_dout, uart_rx_done, uart_rx_busy, frame_err, parity_err});
      end
      sys_rst = 1'b0;
      repeat (5) @(negedge sys_clk);
      n_chk++;
      if ({uart_dout, uart_rx_done, uart_rx_busy, frame_err, parity_err} !== 12'h000) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %h required 000",
                  {uart_dout, uart_rx_done, uart_rx_busy, frame_err, parity_err});
      end
   endtask

   task automatic test_basic;
      int d0, f0, p0;
      d0 = n_done; f0 = n_ferr; p0 = n_perr;
      send_frame(8'hA5, 1'b1, ^8'hA5);
      exp_dout = 8'hA5;
      idle_bits(2);
      n_chk++;
      if (n_done - d0 != 1) begin
         n_fail++; $display("FAIL basic_done_count: got %0d required 1", n_done - d0);
      end
      n_chk++;
      if (uart_dout !== exp_dout || uart_rx_busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_dout_busy: got %h/%b required %h/0", uart_dout, uart_rx_busy, exp_dout);
      end
      n_chk++;
      if (n_ferr != f0 || n_perr != p0) begin
         n_fail++; $display("FAIL basic_no_err: got ferr %0d perr %0d required 0 0", n_ferr - f0, n_perr - p0);
      end
      n_chk++;
      if (done_cyc.size() == 0 || done_cyc[$] - fall_cyc < LAT - 1 || done_cyc[$] - fall_cyc > LAT + 1) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d required %0d +/-1",
                  done_cyc.size() == 0 ? -1 : done_cyc[$] - fall_cyc, LAT);
      end
   endtask

   task automatic test_back_to_back;
      int d0, f0, p0;
      longint gap;
      d0 = n_done; f0 = n_ferr; p0 = n_perr;
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      exp_dout = 8'hFF;
      idle_bits(2);
      n_chk++;
      if (n_done - d0 != 2 || n_ferr != f0 || n_perr != p0) begin
         n_fail++; $display("FAIL b2b_counts: got done %0d ferr %0d perr %0d required 2 0 0",
                            n_done - d0, n_ferr - f0, n_perr - p0);
      end else begin
         n_chk++;
         if (done_byte[$-1] !== 8'h00 || done_byte[$] !== 8'hFF) begin
            n_fail++; $display("FAIL b2b_bytes: got %h %h required 00 ff", done_byte[$-1], done_byte[$]);
         end
         gap = done_cyc[$] - done_cyc[$-1];
         n_chk++;
         if (gap < NBITS * BPS - 1 || gap > NBITS * BPS + 1) begin
            n_fail++; $display("FAIL b2b_gap: got %0d required %0d +/-1", gap, NBITS * BPS);
         end
      end
      n_chk++;
      if (uart_dout !== exp_dout) begin
         n_fail++; $display("FAIL b2b_dout: got %h required %h", uart_dout, exp_dout);
      end
   endtask

   task automatic test_glitch;
      int d0, f0, p0, b0;
      d0 = n_done; f0 = n_ferr; p0 = n_perr; b0 = n_busy_rise;
      @(negedge sys_clk);
      uart_rxd = 1'b0;
      repeat (5) @(negedge sys_clk);
      uart_rxd = 1'b1;
      repeat (2 * BPS) @(negedge sys_clk);
      n_chk++;
      if (n_busy_rise - b0 != 1 || uart_rx_busy !== 1'b0) begin
         n_fail++; $display("FAIL glitch_busy: got rises %0d busy %b required 1 0", n_busy_rise - b0, uart_rx_busy);
      end
      n_chk++;
      if (n_done != d0 || n_ferr != f0 || n_perr != p0 || uart_dout !== exp_dout) begin
         n_fail++; $display("FAIL glitch_no_strobe: got done %0d ferr %0d perr %0d dout %h required 0 0 0 %h",
                            n_done - d0, n_ferr - f0, n_perr - p0, uart_dout, exp_dout);
      end
   endtask

   task automatic test_frame_err;
      int d0, f0, p0;
      d0 = n_done; f0 = n_ferr; p0 = n_perr;
      send_frame(8'h3C, 1'b0, ^8'h3C);
      idle_bits(2);
      n_chk++;
      if (n_ferr - f0 != 1 || n_done != d0 || n_perr != p0) begin
         n_fail++; $display("FAIL ferr_counts: got ferr %0d done %0d perr %0d required 1 0 0",
                            n_ferr - f0, n_done - d0, n_perr - p0);
      end
      n_chk++;
      if (uart_dout !== exp_dout) begin
         n_fail++; $display("FAIL ferr_dout_held: got %h required %h", uart_dout, exp_dout);
      end
   endtask

   task automatic test_reset_mid;
      int d0, f0, p0;
      logic [7:0] d;
      d = 8'h5A;
      @(negedge sys_clk);
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(d[i]);
      uart_rxd = d[4];
      repeat (HALF) @(negedge sys_clk);
      sys_rst = 1'b1;
      #5;
      n_chk++;
      if ({uart_dout, uart_rx_done, uart_rx_busy, frame_err, parity_err} !== 12'h000) begin
         n_fail++; $display("FAIL midreset_outputs: got %h required 000",
                            {uart_dout, uart_rx_done, uart_rx_busy, frame_err, parity_err});
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      exp_dout = 8'h00;
      d0 = n_done; f0 = n_ferr; p0 = n_perr;
      idle_bits(12);
      n_chk++;
      if (n_done != d0 || n_ferr != f0 || n_perr != p0 || uart_dout !== 8'h00) begin
         n_fail++; $display("FAIL midreset_abort: got done %0d ferr %0d perr %0d dout %h required 0 0 0 00",
                            n_done - d0, n_ferr - f0, n_perr - p0, uart_dout);
      end
      send_frame(8'h96, 1'b1, ^8'h96);
      exp_dout = 8'h96;
      idle_bits(1);
      n_chk++;
      if (n_done - d0 != 1 || uart_dout !== exp_dout) begin
         n_fail++; $display("FAIL midreset_recover: got done %0d dout %h required 1 %h",
                            n_done - d0, uart_dout, exp_dout);
      end
   endtask

`ifdef UART_RECV_PARITY_EN
   task automatic test_parity;
      int d0, f0, p0;
      d0 = n_done; f0 = n_ferr; p0 = n_perr;
      send_frame(8'h01, 1'b1, 1'b0);
      idle_bits(1);
      n_chk++;
      if (n_perr - p0 != 1 || n_done != d0 || n_ferr != f0 || uart_dout !== exp_dout) begin
         n_fail++; $display("FAIL parity_bad: got perr %0d done %0d ferr %0d dout %h required 1 0 0 %h",
                            n_perr - p0, n_done - d0, n_ferr - f0, uart_dout, exp_dout);
      end
      d0 = n_done; p0 = n_perr;
      send_frame(8'h01, 1'b1, 1'b1);
      exp_dout = 8'h01;
      idle_bits(1);
      n_chk++;
      if (n_done - d0 != 1 || n_perr != p0 || uart_dout !== exp_dout) begin
         n_fail++; $display("FAIL parity_good: got done %0d perr %0d dout %h required 1 0 %h",
                            n_done - d0, n_perr - p0, uart_dout, exp_dout);
      end
   endtask
`endif

   task automatic test_random;
      logic [7:0] d;
      logic stop, pbit, perr_exp, done_exp;
      int d0, f0, p0, gap;
      for (int k = 0; k < 16; k++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         pbit = (^d) ^ ($urandom_range(0, 4) == 0);
         perr_exp = PAR && (pbit != ^d);
         done_exp = stop && !perr_exp;
         d0 = n_done; f0 = n_ferr; p0 = n_perr;
         send_frame(d, stop, pbit);
         if (done_exp) exp_dout = d;
         n_chk++;
         if (n_done - d0 != int'(done_exp) || n_ferr - f0 != int'(!stop) || n_perr - p0 != int'(perr_exp)) begin
            n_fail++; $display("FAIL rand_%0d_strobes (byte %h stop %b par %b): got %0d %0d %0d required %0d %0d %0d",
                               k, d, stop, pbit, n_done - d0, n_ferr - f0, n_perr - p0,
                               done_exp, !stop, perr_exp);
         end
         n_chk++;
         if (uart_dout !== exp_dout) begin
            n_fail++; $display("FAIL rand_%0d_dout: got %h required %h", k, uart_dout, exp_dout);
         end
         // a low stop bit needs the line to return high before the next start edge
         gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
         if (gap > 0) idle_bits(gap);
      end
      idle_bits(1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
`ifdef UART_RECV_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
